vz_image_loader: RTL
====================

VZ_IMAGE_LOADER -- requirements
Module: vz_image_loader

Interface
REQ-001 SHALL have parameter DN_ADDR_W, default 24: width of the download byte address.
REQ-002 SHALL have parameter MEM_ADDR_W, default 16: width of the target memory address.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: number of buffered body bytes; power of two, at least 2.
REQ-004 SHALL have parameter IMAGE_INDEX, default 8'd1: the dn_index value this loader accepts.
REQ-005 SHALL have parameter BASIC_END_PTR, default 16'h78F9: address that receives the BASIC end pointer.
REQ-006 SHALL use one clock and an asynchronous active-low reset; the ports are clk_sys (in, 1, system clock) and RESET (in, 1, async active-low reset).
REQ-007 dn_download  in  1  download session active.
REQ-008 dn_wr  in  1  download byte valid for one cycle.
REQ-009 dn_addr  in  DN_ADDR_W  byte offset within the file.
REQ-010 dn_data  in  8  byte value.
REQ-011 dn_index  in  8  OSD file slot.
REQ-012 mem_req  out  1  write request, held until accepted.
REQ-013 mem_ack  in  1  write accepted this cycle.
REQ-014 mem_addr  out  MEM_ADDR_W  write address.
REQ-015 mem_data  out  8  write data.
REQ-016 busy  out  1  load in progress.
REQ-017 done  out  1  one-cycle pulse on successful completion.
REQ-018 err  out  2  status: 0 ok, 1 bad magic, 2 overflow, 3 address wrap; sticky until the next session starts.
REQ-019 file_type  out  8  header byte 21: F0 = BASIC, F1 = binary.
REQ-020 start_addr  out  16  header bytes 22-23, little-endian.
REQ-021 autorun  out  1  one-cycle pulse with done when file_type is F1.

Function
REQ-022 States SHALL be IDLE, HEADER, BODY, DRAIN, PTR_LO, PTR_HI, DONE, FAIL.
REQ-023 IDLE SHALL go to HEADER on the rising edge of dn_download when dn_index equals IMAGE_INDEX; err, file_type and start_addr SHALL be cleared on entry.
REQ-024 HEADER SHALL capture bytes 0-23 by their dn_addr value; the loader SHALL NOT assume contiguous strobes.
REQ-025 Bytes 0-3 SHALL equal "VZF0" or "VZFO"; any other value SHALL set err=1 and go to FAIL.
REQ-026 Bytes 4-20 (file name) SHALL be ignored.
REQ-027 After byte 23, HEADER SHALL go to BODY.
REQ-028 In BODY, byte n (dn_addr >= 24) SHALL be pushed into the FIFO tagged with address start_addr + (n - 24).
REQ-029 A push into a full FIFO SHALL set err=2 and go to FAIL.
REQ-030 A computed address above 2^MEM_ADDR_W - 1 SHALL set err=3, SHALL NOT issue that write, and SHALL go to FAIL.
REQ-031 The FIFO head SHALL drive mem_req, mem_addr and mem_data.
REQ-032 The FIFO SHALL pop on the cycle mem_req && mem_ack.
REQ-033 A push and a pop in the same cycle SHALL both complete, leaving the count unchanged; this SHALL also hold when the FIFO is full.
REQ-034 mem_addr and mem_data SHALL NOT change while mem_req is high and mem_ack is low.
REQ-035 The falling edge of dn_download SHALL move BODY to DRAIN; a fall during HEADER SHALL set err=1 and go to FAIL.
REQ-036 DRAIN SHALL wait until the FIFO is empty and mem_req is low.
REQ-037 From DRAIN, file_type F0 SHALL go to PTR_LO; any other type SHALL go to DONE.
REQ-038 PTR_LO SHALL write the low byte of end = last body address + 1 to BASIC_END_PTR.
REQ-039 PTR_HI SHALL write the high byte of end to BASIC_END_PTR + 1.
REQ-040 PTR_LO and PTR_HI SHALL each advance on mem_ack.
REQ-041 DONE SHALL pulse done for one cycle, pulse autorun when file_type is F1, and return to IDLE.
REQ-042 FAIL SHALL discard the FIFO, drop mem_req, and return to IDLE when dn_download is low.
REQ-043 busy SHALL be high in every state except IDLE.
REQ-044 Latency: a byte accepted into an empty FIFO SHALL assert mem_req on the next cycle.
REQ-045 A new rising edge of dn_download in any non-IDLE state SHALL abort the current load and restart in HEADER.

Reset
REQ-046 Asserting RESET low SHALL immediately force IDLE, an empty FIFO, and all outputs to 0.
REQ-047 Assertion mid-operation SHALL cancel any pending write with no partial handshake.
REQ-048 Operation SHALL resume on the first clk_sys edge after RESET is released.

Structure
REQ-049 Package vz_pkg SHALL hold the state enum, the err codes, the magic constants, and the F0/F1 type codes.
REQ-050 The FIFO SHALL be sub-module vz_byte_fifo, parametrised by FIFO_DEPTH and MEM_ADDR_W+8 data width, with full/empty flags and same-cycle push/pop.

Verification
REQ-051 VZF0 header, F1 type, start 8000h, 3 body bytes, mem_ack always 1 -> writes to 8000h, 8001h, 8002h; done and autorun pulse together; err=0.
REQ-052 F0 type, start 7AE9h, 16 body bytes -> 16 body writes, then 78F9h<=F9h and 78FAh<=7Ah; autorun stays 0.
REQ-053 Magic "ABCD" -> err=1, no mem_req ever, busy stays high until dn_download falls.
REQ-054 Strobe every cycle with mem_ack held low, FIFO_DEPTH=4 -> the 5th body byte sets err=2, mem_req drops, done never pulses.
REQ-055 Start FFFEh with 3 body bytes -> writes FFFEh and FFFFh, then err=3 with no third write.
REQ-056 RESET low during BODY with mem_req high -> mem_req=0, busy=0 and the FIFO empty in the same cycle; a fresh load afterwards completes normally.

Source files
------------

// File: rtl/vz_pkg.sv
// Shared types and constants for the VZ image loader.
// Ports: none; this package holds the FSM state enum, the status codes, the header magic bytes
//        and the file type codes.
package vz_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HEADER = 3'd1,
      ST_BODY   = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_PTR_LO = 3'd4,
      ST_PTR_HI = 3'd5,
      ST_DONE   = 3'd6,
      ST_FAIL   = 3'd7
   } vz_state_e;

   typedef enum logic [1:0] {
      ERR_OK       = 2'd0,
      ERR_MAGIC    = 2'd1,
      ERR_OVERFLOW = 2'd2,
      ERR_WRAP     = 2'd3
   } vz_err_e;

   // "VZF0" and "VZFO" are both accepted; only the last byte differs.
   localparam logic [7:0] MAGIC_V = 8'h56;
   localparam logic [7:0] MAGIC_Z = 8'h5A;
   localparam logic [7:0] MAGIC_F = 8'h46;
   localparam logic [7:0] MAGIC_0 = 8'h30;
   localparam logic [7:0] MAGIC_O = 8'h4F;

   localparam logic [7:0] TYPE_BASIC  = 8'hF0;
   localparam logic [7:0] TYPE_BINARY = 8'hF1;

   localparam int HDR_LEN = 24;

   // Checks one magic byte against its position in the header.
   function automatic logic magic_ok(input logic [1:0] idx, input logic [7:0] b);
      logic ok;
      ok = 1'b0;
      case (idx)
         2'd0: ok = (b == MAGIC_V);
         2'd1: ok = (b == MAGIC_Z);
         2'd2: ok = (b == MAGIC_F);
         2'd3: ok = (b == MAGIC_0) || (b == MAGIC_O);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/vz_byte_fifo.sv
// Small synchronous FIFO holding {address, byte} write entries for the loader.
// Latency: a pushed entry is visible at the head on the next cycle; pop is same-cycle.
// Backpressure: a push while full only succeeds together with a pop; clr_i empties it at once.
// Ports: clk_i/rst_ni clock and async active-low reset, clr_i synchronous flush, push_i/push_dat_i
//        write side, pop_i read side, full_o/empty_o flags, head_dat_o current head entry.
module vz_byte_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 24
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_dat_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W:0]   wr_ptr_q;
   logic [PTR_W:0]   rd_ptr_q;
   logic             do_push;
   logic             do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

   // When full, a simultaneous pop frees the slot being written: the head is read
   // combinationally this cycle before the new entry lands on the clock edge.
   assign do_push = push_i && (!full_o || pop_i);
   assign do_pop  = pop_i && !empty_o;

   assign head_dat_o = mem_q[rd_ptr_q[PTR_W-1:0]];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !clr_i) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_dat_i;
   end

endmodule

// File: rtl/vz_image_loader.sv
// Loads a VZ (.vz) image from the OSD download stream into target memory, then patches the BASIC end pointer.
// Latency: a body byte accepted into an empty FIFO raises mem_req on the next cycle.
// Backpressure: none towards the download side; a body byte hitting a full FIFO aborts with err=2.
// Ports: clk_sys/RESET clock and async active-low reset; dn_* download stream (session, strobe,
//        byte offset, byte, file slot); mem_req/mem_ack/mem_addr/mem_data write port held until
//        acked; busy/done/err/file_type/start_addr/autorun status towards the host.
module vz_image_loader
   import vz_pkg::*;
#(
   parameter int          DN_ADDR_W     = 24,
   parameter int          MEM_ADDR_W    = 16,
   parameter int          FIFO_DEPTH    = 4,
   parameter logic [7:0]  IMAGE_INDEX   = 8'd1,
   parameter logic [15:0] BASIC_END_PTR = 16'h78F9
) (
   input  logic                  clk_sys,
   input  logic                  RESET,
   input  logic                  dn_download,
   input  logic                  dn_wr,
   input  logic [DN_ADDR_W-1:0]  dn_addr,
   input  logic [7:0]            dn_data,
   input  logic [7:0]            dn_index,
   output logic                  mem_req,
   input  logic                  mem_ack,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   output logic [7:0]            mem_data,
   output logic                  busy,
   output logic                  done,
   output logic [1:0]            err,
   output logic [7:0]            file_type,
   output logic [15:0]           start_addr,
   output logic                  autorun
);

   localparam int FIFO_W = MEM_ADDR_W + 8;
   localparam int MAX_AW = (DN_ADDR_W > MEM_ADDR_W) ? DN_ADDR_W : MEM_ADDR_W;
   // One spare bit above every operand so the address sum cannot silently wrap.
   localparam int SUM_W  = ((MAX_AW > 16) ? MAX_AW : 16) + 1;

   vz_state_e   state_q, state_d;
   vz_err_e     err_q, err_d;
   logic [7:0]  ftype_q, ftype_d;
   logic [15:0] start_q, start_d;
   logic [15:0] end_q, end_d;
   logic        dl_q;

   logic             dl_rise, dl_fall, session_start;
   logic             is_body, body_wrap;
   logic [SUM_W-1:0] body_sum;

   logic              fifo_push, fifo_pop, fifo_clr;
   logic              fifo_full, fifo_empty, fifo_req;
   logic [FIFO_W-1:0] fifo_head;
   logic              ptr_lo, ptr_hi;

   assign dl_rise       = dn_download && !dl_q;
   assign dl_fall       = !dn_download && dl_q;
   assign session_start = dl_rise && (dn_index == IMAGE_INDEX);

   assign is_body   = (dn_addr >= DN_ADDR_W'(HDR_LEN));
   assign body_sum  = SUM_W'(start_q) + SUM_W'(dn_addr) - SUM_W'(HDR_LEN);
   assign body_wrap = ((body_sum >> MEM_ADDR_W) != '0);

   // Only BODY and DRAIN expose the FIFO head; any abort path flushes it.
   assign fifo_req = !fifo_empty && ((state_q == ST_BODY) || (state_q == ST_DRAIN));
   assign fifo_pop = fifo_req && mem_ack;
   assign ptr_lo   = (state_q == ST_PTR_LO);
   assign ptr_hi   = (state_q == ST_PTR_HI);

   vz_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FIFO_W)
   ) u_fifo (
      .clk_i      (clk_sys),
      .rst_ni     (RESET),
      .clr_i      (fifo_clr),
      .push_i     (fifo_push),
      .push_dat_i ({MEM_ADDR_W'(body_sum), dn_data}),
      .pop_i      (fifo_pop),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .head_dat_o (fifo_head)
   );

   always_ff @(posedge clk_sys or negedge RESET) begin
      if (!RESET) begin
         state_q <= ST_IDLE;
         err_q   <= ERR_OK;
         ftype_q <= '0;
         start_q <= '0;
         end_q   <= '0;
         dl_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         ftype_q <= ftype_d;
         start_q <= start_d;
         end_q   <= end_d;
         dl_q    <= dn_download;
      end
   end

   always_comb begin
      state_d   = state_q;
      err_d     = err_q;
      ftype_d   = ftype_q;
      start_d   = start_q;
      end_d     = end_q;
      fifo_push = 1'b0;
      fifo_clr  = 1'b0;

      if (session_start) begin
         // A new session restarts from any state, discarding whatever was in flight.
         state_d  = ST_HEADER;
         err_d    = ERR_OK;
         ftype_d  = '0;
         start_d  = '0;
         fifo_clr = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: ;
            ST_HEADER: begin
               // Header bytes are placed by offset, so strobes may arrive in any order.
               if (dn_wr && !is_body) begin
                  case (dn_addr[4:0])
                     5'd0, 5'd1, 5'd2, 5'd3: begin
                        if (!magic_ok(dn_addr[1:0], dn_data)) begin
                           err_d   = ERR_MAGIC;
                           state_d = ST_FAIL;
                        end
                     end
                     5'd21: ftype_d = dn_data;
                     5'd22: start_d[7:0] = dn_data;
                     5'd23: begin
                        start_d[15:8] = dn_data;
                        // An empty body leaves the end pointer at the start address.
                        end_d   = {dn_data, start_q[7:0]};
                        state_d = ST_BODY;
                     end
                     default: ;
                  endcase
               end
               if (dl_fall) begin
                  err_d   = ERR_MAGIC;
                  state_d = ST_FAIL;
               end
            end
            ST_BODY: begin
               if (dn_wr && is_body) begin
                  if (body_wrap) begin
                     err_d   = ERR_WRAP;
                     state_d = ST_FAIL;
                  end else if (fifo_full && !fifo_pop) begin
                     err_d   = ERR_OVERFLOW;
                     state_d = ST_FAIL;
                  end else begin
                     fifo_push = 1'b1;
                     end_d     = 16'(body_sum) + 16'd1;
                  end
               end
               if (dl_fall && (state_d == ST_BODY)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
               if (fifo_empty) state_d = (ftype_q == TYPE_BASIC) ? ST_PTR_LO : ST_DONE;
            end
            ST_PTR_LO: if (mem_ack) state_d = ST_PTR_HI;
            ST_PTR_HI: if (mem_ack) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            ST_FAIL:   if (!dn_download) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end

      if (state_d == ST_FAIL) fifo_clr = 1'b1;
   end

   // Address/data are forced to zero whenever no request is pending, so they are 0 in reset.
   always_comb begin
      mem_req  = 1'b0;
      mem_addr = '0;
      mem_data = '0;
      if (ptr_lo) begin
         mem_req  = 1'b1;
         mem_addr = MEM_ADDR_W'(BASIC_END_PTR);
         mem_data = end_q[7:0];
      end else if (ptr_hi) begin
         mem_req  = 1'b1;
         mem_addr = MEM_ADDR_W'(BASIC_END_PTR + 16'd1);
         mem_data = end_q[15:8];
      end else if (fifo_req) begin
         mem_req  = 1'b1;
         mem_addr = fifo_head[FIFO_W-1:8];
         mem_data = fifo_head[7:0];
      end
   end

   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_DONE);
   assign autorun    = done && (ftype_q == TYPE_BINARY);
   assign err        = err_q;
   assign file_type  = ftype_q;
   assign start_addr = start_q;

endmodule
